decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode stage of the 16-bit core; sits between fetch and the regfile/ALU execute stage.
//  Accepts one 16-bit instruction per cycle over a valid/ready handshake and registers the decoded
//  fields: regfile read addresses, ALU select, operand-B mux select, immediate, and write-back address/enable.
//  An 8-entry pending-write scoreboard stalls fetch on read-after-write hazards until write-back retires.
// PARAMETERS
//  DATA_W    16  datapath / instruction width
//  ADDR_W    3   register address width
//  NUM_REGS  8   scoreboard entries, equal to 2**ADDR_W
//  CNT_W     16  perf counter width (DECODE_PERF_EN only)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       fetch holds a valid instruction
//  in_instr   in   DATA_W  instruction word
//  in_ready   out  1       decode accepts in_instr this cycle
//  out_valid  out  1       decoded bundle valid
//  out_ready  in   1       execute consumes the bundle this cycle
//  rd0_addr   out  ADDR_W  regfile read port 0 (ALU a)
//  rd1_addr   out  ADDR_W  regfile read port 1 (ALU b)
//  alu_sel    out  4       ALU op select
//  sel_mux    out  1       1: ALU b = imm, 0: ALU b = rd1_data
//  imm        out  DATA_W  sign-extended imm6
//  wr_en      out  1       instruction writes back
//  wr_addr    out  ADDR_W  write-back destination
//  is_branch  out  1       BEQZ/BNEZ
//  illegal    out  1       opcode 1010..1111
//  flush      in   1       squash the held bundle (branch redirect)
//  wb_valid   in   1       write-back retires a register write
//  wb_addr    in   ADDR_W  retired destination
//  stall_cnt  out  CNT_W   hazard-stall cycles (DECODE_PERF_EN)
//  issue_cnt  out  CNT_W   bundles issued (DECODE_PERF_EN)
// BEHAVIOUR
//  - Format: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
//  - op 0000..1000: alu_sel=op, sel_mux=0, rd0=rs1, rd1=rs2; wr_en=1 except 0110/0111.
//  - op 0110/0111 (BEQZ/BNEZ): rd0=rs1, is_branch=1, wr_en=0, imm=offset.
//  - op 1001 ADDI: alu_sel=0000, sel_mux=1, rd0=rs1, wr_en=1. imm = {{10{i[5]}}, i[5:0]} for all ops.
//  - op 1010..1111: illegal=1, wr_en=0, is_branch=0, alu_sel=1111 (ALU default, f=0).
//  - Sources: rs1 for all legal ops; rs2 only where sel_mux=0 and op not branch/INV.
//    INV (0001) reads rd1=rs2 only.
//  - hazard = any used source has its scoreboard bit set.
//  - in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
//  - Accept (in_valid && in_ready): outputs load at next edge, latency 1 cycle; sets sb[rd] if wr_en.
//  - out_valid && out_ready without accept: out_valid -> 0. Outputs hold while out_valid && !out_ready.
//  - wb_valid clears sb[wb_addr]. Same cycle, same reg as an accept-set: the set wins (bit stays 1).
//  - flush: out_valid -> 0; clears the held bundle's sb bit if its wr_en=1; no accept that cycle;
//    wb clear still applies.
//  - Reset, including mid-operation: out_valid=0, scoreboard=0, all decoded outputs=0, counters=0.
//    in_ready=0 during the reset cycle.
// CONFIGURATION
//  - DECODE_PERF_EN defined: stall_cnt increments per cycle with in_valid && hazard && !flush;
//    issue_cnt increments per out_valid && out_ready. Both saturate at all-ones; cleared by rst.
//  - Not defined: stall_cnt and issue_cnt are tied to 0; no counter flops.
// TESTING
//  - ADD r1,r2,r3 (0x0298) with out_ready=1 -> next cycle out_valid=1, rd0=2, rd1=3, alu_sel=0, wr_en=1, wr_addr=1.
//  - ADDI r4,r1,-1 (0x987F) -> sel_mux=1, imm=0xFFFF, alu_sel=0, rd0=1, wr_addr=4.
//  - ADD r1 then OR r5,r1,r2 -> in_ready=0 until wb_valid/wb_addr=1; OR accepted the cycle wb arrives.
//  - out_ready=0 for 3 cycles -> outputs hold, in_ready=0; release -> next instruction issues.
//  - flush with held ADD r6 -> out_valid=0, sb[6]=0; an instruction reading r6 is accepted the following cycle.
//  - op 0xB000 -> illegal=1, wr_en=0; with DECODE_PERF_EN, stall_cnt=3 after 3 hazard cycles.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/write-back signal bundle for decode_stage.
// master = surrounding pipeline, slave = the decoder.
interface decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_instr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [3:0]        alu_sel;
    logic              sel_mux;
    logic [DATA_W-1:0] imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              is_branch;
    logic              illegal;
    logic              flush;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  issue_cnt;

    modport master (
        output in_valid, in_instr, out_ready, flush, wb_valid, wb_addr,
        input  in_ready, out_valid, rd0_addr, rd1_addr, alu_sel, sel_mux, imm,
               wr_en, wr_addr, is_branch, illegal, stall_cnt, issue_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready, flush, wb_valid, wb_addr,
        output in_ready, out_valid, rd0_addr, rd1_addr, alu_sel, sel_mux, imm,
               wr_en, wr_addr, is_branch, illegal, stall_cnt, issue_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode with an 8-entry RAW-hazard scoreboard.
// Define DECODE_PERF_EN to build the saturating stall/issue counters.
module decode_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    logic [3:0]               op_p0;
    logic [ADDR_W-1:0]        rd_p0, rs1_p0, rs2_p0;
    logic [3:0]               alu_sel_p0;
    logic                     sel_mux_p0, wr_en_p0, is_branch_p0, illegal_p0;
    logic                     use_rs1_p0, use_rs2_p0;
    logic signed [DATA_W-1:0] imm_p0;

    logic                     vld_p1;
    logic [ADDR_W-1:0]        rd0_p1, rd1_p1, wr_addr_p1;
    logic [3:0]               alu_sel_p1;
    logic                     sel_mux_p1, wr_en_p1, is_branch_p1, illegal_p1;
    logic signed [DATA_W-1:0] imm_p1;

    logic [NUM_REGS-1:0]      sb, sb_eff, sb_next;
    logic                     hazard, accept;

    assign op_p0  = bus.in_instr[15:12];
    assign rd_p0  = bus.in_instr[11:9];
    assign rs1_p0 = bus.in_instr[8:6];
    assign rs2_p0 = bus.in_instr[5:3];
    assign imm_p0 = DATA_W'($signed(bus.in_instr[5:0]));

    always_comb begin
        alu_sel_p0   = op_p0;
        sel_mux_p0   = 1'b0;
        wr_en_p0     = 1'b0;
        is_branch_p0 = 1'b0;
        illegal_p0   = 1'b0;
        use_rs1_p0   = 1'b0;
        use_rs2_p0   = 1'b0;
        if (op_p0 <= 4'd8) begin
            is_branch_p0 = (op_p0 == 4'd6) || (op_p0 == 4'd7);
            wr_en_p0     = !is_branch_p0;
            // INV is single-operand through port 1; branches test rs1 only
            use_rs1_p0   = (op_p0 != 4'd1);
            use_rs2_p0   = !is_branch_p0;
        end else if (op_p0 == 4'd9) begin
            alu_sel_p0 = 4'd0;
            sel_mux_p0 = 1'b1;
            wr_en_p0   = 1'b1;
            use_rs1_p0 = 1'b1;
        end else begin
            alu_sel_p0 = 4'hF;
            illegal_p0 = 1'b1;
        end
    end

    // A retiring write-back releases its register in the same cycle it arrives
    assign sb_eff = bus.wb_valid ? (sb & ~(NUM_REGS'(1) << bus.wb_addr)) : sb;
    assign hazard = (use_rs1_p0 && sb_eff[rs1_p0]) || (use_rs2_p0 && sb_eff[rs2_p0]);

    assign bus.in_ready = !rst && !bus.flush && !hazard && (!vld_p1 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        sb_next = sb_eff;
        if (bus.flush && vld_p1 && wr_en_p1) sb_next[wr_addr_p1] = 1'b0;
        if (accept && wr_en_p0)              sb_next[rd_p0]      = 1'b1;
    end

    // ---- stage p0 -> p1: decoded bundle register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            sb           <= '0;
            rd0_p1       <= '0;
            rd1_p1       <= '0;
            wr_addr_p1   <= '0;
            alu_sel_p1   <= '0;
            sel_mux_p1   <= 1'b0;
            wr_en_p1     <= 1'b0;
            is_branch_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
            imm_p1       <= '0;
        end else begin
            sb <= sb_next;
            if (accept) begin
                vld_p1       <= 1'b1;
                rd0_p1       <= rs1_p0;
                rd1_p1       <= rs2_p0;
                wr_addr_p1   <= rd_p0;
                alu_sel_p1   <= alu_sel_p0;
                sel_mux_p1   <= sel_mux_p0;
                wr_en_p1     <= wr_en_p0;
                is_branch_p1 <= is_branch_p0;
                illegal_p1   <= illegal_p0;
                imm_p1       <= imm_p0;
            end else if (bus.flush || bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.rd0_addr  = rd0_p1;
    assign bus.rd1_addr  = rd1_p1;
    assign bus.wr_addr   = wr_addr_p1;
    assign bus.alu_sel   = alu_sel_p1;
    assign bus.sel_mux   = sel_mux_p1;
    assign bus.wr_en     = wr_en_p1;
    assign bus.is_branch = is_branch_p1;
    assign bus.illegal   = illegal_p1;
    assign bus.imm       = imm_p1;

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] stall_q, issue_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            issue_q <= '0;
        end else begin
            if (bus.in_valid && hazard && !bus.flush) stall_q <= sat_inc(stall_q);
            if (vld_p1 && bus.out_ready)              issue_q <= sat_inc(issue_q);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.issue_cnt = issue_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.issue_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural model.
module tb_decode_stage;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dif ();

    decode_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(8), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rd0;
        logic [2:0]  rd1;
        logic [2:0]  wr_addr;
        logic [3:0]  alu;
        logic        sel_mux;
        logic        wr_en;
        logic        br;
        logic        ill;
        logic [15:0] imm;
    } dec_t;

    // Expected decode straight from the instruction table
    function automatic dec_t ref_decode(input logic [15:0] i);
        dec_t d;
        int op, v;
        op = int'(i[15:12]);
        v  = int'(i[5:0]);
        if (v >= 32) v = v - 64;
        d.op      = i[15:12];
        d.rd0     = i[8:6];
        d.rd1     = i[5:3];
        d.wr_addr = i[11:9];
        d.imm     = 16'(v);
        d.ill     = (op >= 10);
        d.br      = (op == 6 || op == 7);
        d.wr_en   = (op <= 9) && !d.br;
        d.sel_mux = (op == 9);
        d.alu     = d.ill ? 4'hF : (op == 9 ? 4'h0 : 4'(op));
        return d;
    endfunction

    function automatic bit reads(input logic [15:0] i, input int r);
        int op;
        bit u1, u2;
        op = int'(i[15:12]);
        u1 = (op <= 9) && (op != 1);
        u2 = (op <= 5) || (op == 8);
        return (u1 && int'(i[8:6]) == r) || (u2 && int'(i[5:3]) == r);
    endfunction

    bit       m_vld;
    dec_t     m_out;
    bit [7:0] m_sb;
    int       m_stall, m_issue;

    task automatic cycle(input bit r, input bit iv, input logic [15:0] ins, input bit ordy,
                         input bit fl, input bit wbv, input logic [2:0] wba);
        bit haz, rdy, acc;
        dec_t d;
        bit [7:0] sbe;
        @(negedge clk);
        rst           = r;
        dif.in_valid  = iv;
        dif.in_instr  = ins;
        dif.out_ready = ordy;
        dif.flush     = fl;
        dif.wb_valid  = wbv;
        dif.wb_addr   = wba;
        #1;
        d   = ref_decode(ins);
        sbe = m_sb;
        if (wbv) sbe[wba] = 1'b0;
        haz = 1'b0;
        for (int k = 0; k < 8; k++) if (reads(ins, k) && sbe[k]) haz = 1'b1;
        rdy = !r && !fl && !haz && (!m_vld || ordy);
        acc = iv && rdy;

        check("in_ready", dif.in_ready, rdy);
        check("out_valid", dif.out_valid, m_vld);
        if (m_vld) begin
            check("alu_sel", dif.alu_sel, m_out.alu);
            check("sel_mux", dif.sel_mux, m_out.sel_mux);
            check("wr_en", dif.wr_en, m_out.wr_en);
            check("is_branch", dif.is_branch, m_out.br);
            check("illegal", dif.illegal, m_out.ill);
            check("imm", dif.imm, m_out.imm);
            if (!m_out.ill)     check("rd0_addr", dif.rd0_addr, m_out.rd0);
            if (m_out.op <= 8)  check("rd1_addr", dif.rd1_addr, m_out.rd1);
            if (m_out.wr_en)    check("wr_addr", dif.wr_addr, m_out.wr_addr);
        end
`ifdef DECODE_PERF_EN
        check("stall_cnt", dif.stall_cnt, m_stall);
        check("issue_cnt", dif.issue_cnt, m_issue);
`else
        check("stall_cnt_tied", dif.stall_cnt, 0);
        check("issue_cnt_tied", dif.issue_cnt, 0);
`endif

        if (r) begin
            m_vld   = 1'b0;
            m_out   = '0;
            m_sb    = '0;
            m_stall = 0;
            m_issue = 0;
        end else begin
            if (iv && haz && !fl && m_stall < 65535) m_stall++;
            if (m_vld && ordy && m_issue < 65535)    m_issue++;
            if (fl && m_vld && m_out.wr_en) sbe[m_out.wr_addr] = 1'b0;
            if (acc && d.wr_en) sbe[ins[11:9]] = 1'b1;
            m_sb = sbe;
            if (acc) begin
                m_vld = 1'b1;
                m_out = d;
            end else if (fl || ordy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit wbv, input logic [2:0] wba);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, wbv, wba);
    endtask

    initial begin
        logic [2:0] pend[$];
        bit r, iv, ordy, fl, wbv;
        logic [2:0] wba;
        logic [15:0] ins;

        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.out_ready = 1'b0;
        dif.flush     = 1'b0;
        dif.wb_valid  = 1'b0;
        dif.wb_addr   = '0;
        m_vld = 1'b0; m_out = '0; m_sb = '0; m_stall = 0; m_issue = 0;

        // reset and idle state
        cycle(1'b1, 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 3'd0);
        check("rst_in_ready", dif.in_ready, 0);
        idle(1'b0, 3'd0);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_alu_sel", dif.alu_sel, 0);
        check("rst_imm", dif.imm, 0);
        check("rst_wr_en", dif.wr_en, 0);
        check("rst_stall", dif.stall_cnt, 0);

        // ADD r1,r2,r3 then ADDI r4,r1,-1 released by same-cycle write-back of r1
        cycle(1'b0, 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 3'd0);
        check("add_accept", dif.in_ready, 1);
        cycle(1'b0, 1'b1, 16'h987F, 1'b1, 1'b0, 1'b1, 3'd1);
        check("add_valid", dif.out_valid, 1);
        check("add_rd0", dif.rd0_addr, 2);
        check("add_rd1", dif.rd1_addr, 3);
        check("add_alu", dif.alu_sel, 0);
        check("add_wr_en", dif.wr_en, 1);
        check("add_wr_addr", dif.wr_addr, 1);
        check("addi_accept", dif.in_ready, 1);
        idle(1'b1, 3'd4);
        check("addi_sel_mux", dif.sel_mux, 1);
        check("addi_imm", dif.imm, 16'hFFFF);
        check("addi_alu", dif.alu_sel, 0);
        check("addi_rd0", dif.rd0_addr, 1);
        check("addi_wr_addr", dif.wr_addr, 4);

        // RAW hazard: ADD r1 then OR r5,r1,r2 stalls for 3 cycles
        cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 16'h3A50, 1'b1, 1'b0, 1'b0, 3'd0);
            check("raw_stall_ready", dif.in_ready, 0);
        end
        cycle(1'b0, 1'b1, 16'h3A50, 1'b1, 1'b0, 1'b1, 3'd1);
        check("raw_wb_accept", dif.in_ready, 1);
`ifdef DECODE_PERF_EN
        check("stall_cnt_3", dif.stall_cnt, 3);
`else
        check("stall_cnt_off", dif.stall_cnt, 0);
`endif
        idle(1'b1, 3'd5);

        // backpressure on ADD r7 for 3 cycles, then ADD r6 issues
        cycle(1'b0, 1'b1, 16'h0E98, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 16'h0C98, 1'b0, 1'b0, 1'b0, 3'd0);
            check("bp_ready", dif.in_ready, 0);
            check("bp_hold_valid", dif.out_valid, 1);
            check("bp_hold_wr_addr", dif.wr_addr, 7);
        end
        cycle(1'b0, 1'b1, 16'h0C98, 1'b1, 1'b0, 1'b0, 3'd0);
        check("bp_release", dif.in_ready, 1);

        // flush the held ADD r6; a reader of r6 goes next cycle
        cycle(1'b0, 1'b1, 16'h0190, 1'b0, 1'b1, 1'b0, 3'd0);
        check("flush_ready", dif.in_ready, 0);
        check("flush_held_addr", dif.wr_addr, 6);
        cycle(1'b0, 1'b1, 16'h0190, 1'b1, 1'b0, 1'b0, 3'd0);
        check("flush_valid", dif.out_valid, 0);
        check("flush_r6_free", dif.in_ready, 1);

        // illegal opcode
        cycle(1'b0, 1'b1, 16'hB000, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(1'b0, 3'd0);
        check("ill_flag", dif.illegal, 1);
        check("ill_wr_en", dif.wr_en, 0);
        check("ill_alu", dif.alu_sel, 4'hF);
        check("ill_branch", dif.is_branch, 0);

        // randomized traffic, including occasional mid-stream reset
        cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 199) == 0);
            iv   = ($urandom_range(0, 9) < 8);
            ins  = 16'($urandom());
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 19) == 0);
            wbv  = ($urandom_range(0, 3) == 0);
            pend.delete();
            for (int k = 0; k < 8; k++) if (m_sb[k]) pend.push_back(3'(k));
            if (pend.size() > 0 && $urandom_range(0, 9) < 8)
                wba = pend[$urandom_range(0, pend.size() - 1)];
            else
                wba = 3'($urandom_range(0, 7));
            cycle(r, iv, ins, ordy, fl, wbv, wba);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
